// File: rtl/sample_decimator_pkg.sv
// -----------------------------------------------------------------------------
// sample_decimator_pkg
// Shared constants for the ADC front-end and downstream DSP stages.
//   ADC_WIDTH    : raw ADC sample width (unsigned offset-binary)
//   OUT_WIDTH    : width of the signed, DC-centred output sample
//   ADC_MIDSCALE : offset-binary code representing zero
//   ADC_MAX      : full-scale ADC code (also a clip indicator)
//   OUT_SHIFT    : left shift applied to scale ADC_WIDTH up to OUT_WIDTH
// -----------------------------------------------------------------------------
package sample_decimator_pkg;

    localparam int ADC_WIDTH    = 12;
    localparam int OUT_WIDTH    = 16;
    localparam int ADC_MIDSCALE = 2048;
    localparam int ADC_MAX      = 4095;
    localparam int OUT_SHIFT    = 4;

endpackage : sample_decimator_pkg

// File: rtl/sample_decimator.sv
// -----------------------------------------------------------------------------
// sample_decimator
// Box-car decimator: averages windows of 2^DECIM_SHIFT accepted ADC samples and
// emits one signed, DC-centred, left-justified result per window.
//
// Ports
//   clk_in     : single clock, rising edge
//   reset_in   : synchronous active-high reset, dominates ready_in
//   ready_in   : one-cycle strobe, signal_in valid
//   signal_in  : 12-bit offset-binary ADC sample
//   done_out   : one-cycle strobe, signal_out/clip_out updated
//   signal_out : ((mean - 2048) << 4), held until the next done_out
//   clip_out   : a sample of the emitted window was 0 or 4095
// -----------------------------------------------------------------------------
module sample_decimator
    import sample_decimator_pkg::*;
#(
    parameter int DECIM_SHIFT = 3
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        ready_in,
    input  logic [ADC_WIDTH-1:0]        signal_in,
    output logic                        done_out,
    output logic signed [OUT_WIDTH-1:0] signal_out,
    output logic                        clip_out
);

    localparam int N     = 1 << DECIM_SHIFT;
    localparam int ACC_W = ADC_WIDTH + DECIM_SHIFT;
    // Keep the counter at least one bit wide so DECIM_SHIFT = 0 still elaborates;
    // in that case it simply stays at 0 and every sample completes a window.
    localparam int CNT_W = (DECIM_SHIFT > 0) ? DECIM_SHIFT : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    logic [CNT_W-1:0]     r_count;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_clip;
    logic                 r_done;
    logic [OUT_WIDTH-1:0] r_signal;
    logic                 r_clip_out;

    logic                 w_last;
    logic                 w_smp_clip;
    logic [ACC_W-1:0]     w_sum;
    logic [ADC_WIDTH-1:0] w_mean;
    logic [ADC_WIDTH-1:0] w_centred;

    assign w_last     = (r_count == LAST_CNT);
    assign w_smp_clip = (signal_in == '0) || (signal_in == ADC_WIDTH'(ADC_MAX));
    // ACC_W bits hold N * ADC_MAX exactly, so the sum cannot wrap.
    assign w_sum      = r_acc + ACC_W'(signal_in);
    assign w_mean     = ADC_WIDTH'(w_sum >> DECIM_SHIFT);
    // Subtracting midscale from an offset-binary code is just an MSB flip,
    // yielding the two's-complement value directly.
    assign w_centred  = w_mean ^ ADC_WIDTH'(ADC_MIDSCALE);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_clip     <= 1'b0;
            r_done     <= 1'b0;
            r_signal   <= '0;
            r_clip_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ready_in) begin
                if (w_last) begin
                    r_count    <= '0;
                    r_acc      <= '0;
                    r_clip     <= 1'b0;
                    r_done     <= 1'b1;
                    r_signal   <= {w_centred, {OUT_SHIFT{1'b0}}};
                    r_clip_out <= r_clip | w_smp_clip;
                end else begin
                    r_count <= r_count + 1'b1;
                    r_acc   <= w_sum;
                    r_clip  <= r_clip | w_smp_clip;
                end
            end
        end
    end

    assign done_out   = r_done;
    assign signal_out = r_signal;
    assign clip_out   = r_clip_out;

endmodule : sample_decimator

// File: tb/tb_sample_decimator.sv
module tb_sample_decimator;

    logic               clk_in = 1'b0;
    logic               reset_in;
    logic               ready_in;
    logic [11:0]        signal_in;
    logic               done_out;
    logic signed [15:0] signal_out;
    logic               clip_out;

    logic               s0_ready;
    logic [11:0]        s0_data;
    logic               s0_done;
    logic signed [15:0] s0_out;
    logic               s0_clip;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state for the DECIM_SHIFT=3 instance
    int m_win[$];
    int exp_done = 0;
    int exp_out  = 0;
    int exp_clip = 0;

    always #5 clk_in = ~clk_in;

    sample_decimator #(.DECIM_SHIFT(3)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .ready_in  (ready_in),
        .signal_in (signal_in),
        .done_out  (done_out),
        .signal_out(signal_out),
        .clip_out  (clip_out)
    );

    sample_decimator #(.DECIM_SHIFT(0)) dut0 (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .ready_in  (s0_ready),
        .signal_in (s0_data),
        .done_out  (s0_done),
        .signal_out(s0_out),
        .clip_out  (s0_clip)
    );

    // Mean of a window of 8, minus midscale, times 16; clip if any rail code.
    task automatic model_step(input logic rst, input logic rdy, input int d);
        int sum;
        if (rst) begin
            m_win.delete();
            exp_done = 0;
            exp_out  = 0;
            exp_clip = 0;
        end else begin
            exp_done = 0;
            if (rdy) begin
                m_win.push_back(d);
                if (m_win.size() == 8) begin
                    sum      = 0;
                    exp_clip = 0;
                    foreach (m_win[k]) begin
                        sum += m_win[k];
                        if (m_win[k] == 0 || m_win[k] == 4095) exp_clip = 1;
                    end
                    exp_out  = (sum / 8 - 2048) * 16;
                    exp_done = 1;
                    m_win.delete();
                end
            end
        end
    endtask

    // Drive one cycle of main-DUT inputs, advance past the edge, update model.
    task automatic cyc(input logic rst, input logic rdy, input int d);
        reset_in  = rst;
        ready_in  = rdy;
        signal_in = 12'(d);
        @(posedge clk_in);
        #1;
        model_step(rst, rdy, d);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 4095);
            n_cmp++;
            if (done_out !== 1'b0 || signal_out !== 16'sd0 || clip_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: done=%b out=%0d clip=%b, required 0/0/0",
                         done_out, signal_out, clip_out);
            end
            n_cmp++;
            if (s0_done !== 1'b0 || s0_out !== 16'sd0 || s0_clip !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state_s0: done=%b out=%0d clip=%b, required 0/0/0",
                         s0_done, s0_out, s0_clip);
            end
        end
    endtask

    task automatic test_midscale();
        int dones = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, i < 8, 2048);
            if (done_out === 1'b1) dones++;
            n_cmp++;
            if (done_out !== (i == 7)) begin
                n_fail++;
                $display("FAIL midscale_done cycle %0d: got %b, required %b", i + 1, done_out, i == 7);
            end
        end
        n_cmp++;
        if (dones != 1 || signal_out !== 16'sd0 || clip_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midscale_result: dones=%0d out=%0d clip=%b, required 1/0/0",
                     dones, signal_out, clip_out);
        end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 4095);
        n_cmp++;
        if (done_out !== 1'b1 || signal_out !== 16'sd32752 || clip_out !== 1'b1) begin
            n_fail++;
            $display("FAIL full_scale_high: done=%b out=%0d clip=%b, required 1/32752/1",
                     done_out, signal_out, clip_out);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 0);
        n_cmp++;
        if (done_out !== 1'b1 || signal_out !== -16'sd32768 || clip_out !== 1'b1) begin
            n_fail++;
            $display("FAIL full_scale_low: done=%b out=%0d clip=%b, required 1/-32768/1",
                     done_out, signal_out, clip_out);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1000 + i);
        n_cmp++;
        if (done_out !== 1'b1 || signal_out !== -16'sd16720 || clip_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_result: done=%b out=%0d clip=%b, required 1/-16720/0",
                     done_out, signal_out, clip_out);
        end
        cyc(1'b0, 1'b0, 0);
        n_cmp++;
        if (done_out !== 1'b0 || signal_out !== -16'sd16720) begin
            n_fail++;
            $display("FAIL ramp_hold: done=%b out=%0d, required 0/-16720", done_out, signal_out);
        end
    endtask

    task automatic test_reset_mid_window();
        int dones = 0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 500);
        cyc(1'b1, 1'b1, 500);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, i < 8, 3000);
            if (done_out === 1'b1) dones++;
            n_cmp++;
            if (done_out !== (i == 7)) begin
                n_fail++;
                $display("FAIL reset_mid_done step %0d: got %b, required %b", i, done_out, i == 7);
            end
        end
        n_cmp++;
        if (dones != 1 || signal_out !== 16'sd15232 || clip_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_result: dones=%0d out=%0d clip=%b, required 1/15232/0",
                     dones, signal_out, clip_out);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        for (int i = 0; i < 18; i++) begin
            d = (i < 16) ? $urandom_range(1, 4094) : 0;
            cyc(1'b0, i < 16, d);
            n_cmp++;
            if (done_out !== (i == 7 || i == 15)) begin
                n_fail++;
                $display("FAIL b2b_done cycle %0d: got %b, required %b",
                         i + 1, done_out, (i == 7 || i == 15));
            end
            n_cmp++;
            if (int'(signal_out) !== exp_out || int'(clip_out) !== exp_clip) begin
                n_fail++;
                $display("FAIL b2b_value cycle %0d: out=%0d clip=%b, required %0d/%0d",
                         i + 1, signal_out, clip_out, exp_out, exp_clip);
            end
        end
    endtask

    task automatic test_random_gapped();
        int d;
        logic rdy, rst;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            rdy = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0:       d = 0;
                1:       d = 4095;
                default: d = $urandom_range(0, 4095);
            endcase
            cyc(rst, rdy, d);
            n_cmp++;
            if (int'(done_out) !== exp_done || int'(signal_out) !== exp_out ||
                int'(clip_out) !== exp_clip) begin
                n_fail++;
                $display("FAIL random step %0d: done=%b out=%0d clip=%b, required %0d/%0d/%0d",
                         i, done_out, signal_out, clip_out, exp_done, exp_out, exp_clip);
            end
        end
    endtask

    task automatic test_shift0();
        int vals[3] = '{2049, 0, 4095};
        int outs[3] = '{16, -32768, 32752};
        int clps[3] = '{0, 1, 1};
        int d;
        for (int i = 0; i < 3; i++) begin
            s0_ready = 1'b1;
            s0_data  = 12'(vals[i]);
            cyc(1'b0, 1'b0, 0);
            n_cmp++;
            if (s0_done !== 1'b1 || int'(s0_out) !== outs[i] || int'(s0_clip) !== clps[i]) begin
                n_fail++;
                $display("FAIL shift0_vector %0d: done=%b out=%0d clip=%b, required 1/%0d/%0d",
                         i, s0_done, s0_out, s0_clip, outs[i], clps[i]);
            end
            s0_ready = 1'b0;
            cyc(1'b0, 1'b0, 0);
            n_cmp++;
            if (s0_done !== 1'b0 || int'(s0_out) !== outs[i]) begin
                n_fail++;
                $display("FAIL shift0_hold %0d: done=%b out=%0d, required 0/%0d",
                         i, s0_done, s0_out, outs[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            d        = $urandom_range(0, 4095);
            s0_ready = 1'b1;
            s0_data  = 12'(d);
            cyc(1'b0, 1'b0, 0);
            n_cmp++;
            if (s0_done !== 1'b1 || int'(s0_out) !== (d - 2048) * 16 ||
                int'(s0_clip) !== int'(d == 0 || d == 4095)) begin
                n_fail++;
                $display("FAIL shift0_random in=%0d: done=%b out=%0d clip=%b, required 1/%0d",
                         d, s0_done, s0_out, s0_clip, (d - 2048) * 16);
            end
        end
        s0_ready = 1'b0;
    endtask

    initial begin
        reset_in  = 1'b1;
        ready_in  = 1'b0;
        signal_in = '0;
        s0_ready  = 1'b0;
        s0_data   = '0;
        test_reset();
        test_midscale();
        test_full_scale();
        test_ramp();
        test_reset_mid_window();
        test_back_to_back();
        test_random_gapped();
        test_shift0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sample_decimator
